// File: rtl/chu_gpi_edge.sv
// chu_gpi_edge: debounced general-purpose input port with sticky rise/fall
// event registers, a per-bit interrupt mask and a level interrupt output.
//
// Bus strobes: an access takes effect only in a cycle where cs is high.
// cs && write commits on the rising edge of clk. read is informational;
// rd_data is a pure function of addr and the registers. There is no
// valid/ready stall, so every access completes in the cycle it is presented.
module chu_gpi_edge #(
    parameter int W        = 8,
    parameter int DB_TICKS = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         cs,
    input  logic         read,
    input  logic         write,
    input  logic [4:0]   addr,
    input  logic [31:0]  wr_data,
    output logic [31:0]  rd_data,
    input  logic [W-1:0] din,
    output logic         irq
);

    localparam int CW = $clog2(DB_TICKS + 1);

    logic [W-1:0]  sync1, sync2, sync3;
    logic [CW-1:0] cnt;
    logic [W-1:0]  data_reg, rise_reg, fall_reg, mask_reg;

    logic          stable, load, wr_en;
    logic [W-1:0]  rise_set, fall_set, rise_clr, fall_clr;

    // read carries no state effect and wr_data above W has no destination.
    logic unused_bus;
    assign unused_bus = read ^ (^wr_data);

    assign stable   = (sync2 == sync3);
    assign load     = stable && (cnt == CW'(DB_TICKS));
    assign wr_en    = cs && write;

    // Event bits only change on the cycle data_reg actually takes a new value.
    assign rise_set = load ? (sync2 & ~data_reg) : '0;
    assign fall_set = load ? (~sync2 & data_reg) : '0;
    assign rise_clr = (wr_en && addr == 5'd1) ? wr_data[W-1:0] : '0;
    assign fall_clr = (wr_en && addr == 5'd2) ? wr_data[W-1:0] : '0;

    // Two-flop synchronizer plus one delay stage used for change detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    // Stability counter: restarts on any bit change, saturates at DB_TICKS.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (!stable) begin
            cnt <= '0;
        end else if (cnt != CW'(DB_TICKS)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Debounced value only advances once the input has been stable long enough.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_reg <= '0;
        end else if (load) begin
            data_reg <= sync2;
        end
    end

    // Sticky event bits, write-1-to-clear; a simultaneous set beats the clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rise_reg <= '0;
            fall_reg <= '0;
        end else begin
            rise_reg <= (rise_reg & ~rise_clr) | rise_set;
            fall_reg <= (fall_reg & ~fall_clr) | fall_set;
        end
    end

    // Interrupt mask, written directly from the bus.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_reg <= '0;
        end else if (wr_en && addr == 5'd3) begin
            mask_reg <= wr_data[W-1:0];
        end
    end

    // Read mux; unmapped addresses and bits above W return zero.
    always_comb begin
        rd_data = '0;
        case (addr)
            5'd0:    rd_data = 32'(data_reg);
            5'd1:    rd_data = 32'(rise_reg);
            5'd2:    rd_data = 32'(fall_reg);
            5'd3:    rd_data = 32'(mask_reg);
            default: rd_data = '0;
        endcase
    end

    // Level interrupt straight from the registers, no extra pipeline stage.
    assign irq = |((rise_reg | fall_reg) & mask_reg);

endmodule

// File: tb/tb_chu_gpi_edge.sv
// tb_chu_gpi_edge: table-driven register checks, hand-written timing
// sequences and randomized stimulus against a history-based reference model.
module tb_chu_gpi_edge;

    localparam int W  = 8;
    localparam int DB = 4;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cs = 1'b0, read = 1'b0, write = 1'b0;
    logic [4:0]  addr = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] rd_data;
    logic [W-1:0] din = '0;
    logic        irq;

    always #10 clk = ~clk;

    chu_gpi_edge #(.W(W), .DB_TICKS(DB)) dut (
        .clk(clk), .reset_n(reset_n), .cs(cs), .read(read), .write(write),
        .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .din(din), .irq(irq)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model ----------------
    // The debounced value becomes v at an edge when the din samples taken at
    // the DB+2 edges ending two edges earlier all equal v (two synchronizer
    // stages of delay, then DB+1 matching samples). m_hist[0] is the newest.
    logic [W-1:0] m_hist[$];
    logic [W-1:0] m_data, m_rise, m_fall, m_mask;

    function automatic void model_clear();
        m_hist.delete();
        for (int i = 0; i < DB + 4; i++) m_hist.push_back('0);
        m_data = '0; m_rise = '0; m_fall = '0; m_mask = '0;
    endfunction

    function automatic void model_step();
        logic         st;
        logic [W-1:0] nd, cr, cf;
        m_hist.push_front(din);
        while (m_hist.size() > DB + 4) void'(m_hist.pop_back());
        st = 1'b1;
        for (int i = 3; i <= DB + 3; i++) if (m_hist[i] != m_hist[2]) st = 1'b0;
        nd = st ? m_hist[2] : m_data;
        cr = (cs && write && addr == 5'd1) ? wr_data[W-1:0] : '0;
        cf = (cs && write && addr == 5'd2) ? wr_data[W-1:0] : '0;
        m_rise = (m_rise & ~cr) | (nd & ~m_data);
        m_fall = (m_fall & ~cf) | (~nd & m_data);
        if (cs && write && addr == 5'd3) m_mask = wr_data[W-1:0];
        m_data = nd;
    endfunction

    function automatic logic [31:0] model_rd(input logic [4:0] a);
        case (a)
            5'd0:    return 32'(m_data);
            5'd1:    return 32'(m_rise);
            5'd2:    return 32'(m_fall);
            5'd3:    return 32'(m_mask);
            default: return 32'h0;
        endcase
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    // One clock: model advances on the edge, DUT compared on the falling edge.
    task automatic tick();
        @(posedge clk);
        if (reset_n) model_step(); else model_clear();
        @(negedge clk);
        check("model_rd", rd_data, model_rd(addr));
        check("model_irq", {31'b0, irq}, {31'b0, ^(|((m_rise | m_fall) & m_mask))});
    endtask

    task automatic read_chk(input string name, input logic [4:0] a, input logic [31:0] exp);
        addr = a; read = 1'b1;
        #1;
        check(name, rd_data, exp);
        read = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        cs = 1'b0; write = 1'b0; din = '0;
        reset_n = 1'b0;
        model_clear();
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (10) tick();
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
        tick();
        cs = 1'b0; write = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0]  din;
        logic        cs;
        logic        wr;
        logic [4:0]  a;
        logic [31:0] wd;
        int          ncyc;
        logic [7:0]  e_data, e_rise, e_fall, e_mask;
        logic        e_irq;
    } step_t;

    step_t steps[11];

    initial begin
        //          din    cs    wr    a     wd       n  data   rise   fall   mask   irq
        steps[0]  = '{8'h05, 1'b0, 1'b0, 5'd0, 32'h00, 7, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
        steps[1]  = '{8'h05, 1'b0, 1'b0, 5'd0, 32'h00, 1, 8'h05, 8'h05, 8'h00, 8'h00, 1'b0};
        steps[2]  = '{8'h05, 1'b1, 1'b1, 5'd3, 32'h01, 1, 8'h05, 8'h05, 8'h00, 8'h01, 1'b1};
        steps[3]  = '{8'h05, 1'b1, 1'b1, 5'd1, 32'hFF, 1, 8'h05, 8'h00, 8'h00, 8'h01, 1'b0};
        steps[4]  = '{8'h04, 1'b0, 1'b0, 5'd0, 32'h00, 8, 8'h04, 8'h00, 8'h01, 8'h01, 1'b1};
        steps[5]  = '{8'h04, 1'b1, 1'b1, 5'd2, 32'h01, 1, 8'h04, 8'h00, 8'h00, 8'h01, 1'b0};
        steps[6]  = '{8'h04, 1'b1, 1'b1, 5'd0, 32'hFF, 1, 8'h04, 8'h00, 8'h00, 8'h01, 1'b0};
        steps[7]  = '{8'h04, 1'b0, 1'b1, 5'd3, 32'h00, 1, 8'h04, 8'h00, 8'h00, 8'h01, 1'b0};
        steps[8]  = '{8'h04, 1'b1, 1'b1, 5'd5, 32'hFF, 1, 8'h04, 8'h00, 8'h00, 8'h01, 1'b0};
        steps[9]  = '{8'h84, 1'b0, 1'b0, 5'd0, 32'h00, 8, 8'h84, 8'h80, 8'h00, 8'h01, 1'b0};
        steps[10] = '{8'h84, 1'b1, 1'b1, 5'd3, 32'h80, 1, 8'h84, 8'h80, 8'h00, 8'h80, 1'b1};
    end

    // ---------------- test sequence ----------------
    initial begin
        int hold;
        model_clear();
        #1;
        check("reset_irq", {31'b0, irq}, 32'h0);
        for (int a = 0; a < 4; a++) read_chk("reset_rd", 5'(a), 32'h0);
        #30;
        reset_n = 1'b1;
        repeat (10) tick();

        // Table-driven register and latency walk.
        for (int i = 0; i < 11; i++) begin
            din = steps[i].din; cs = steps[i].cs; write = steps[i].wr;
            addr = steps[i].a; wr_data = steps[i].wd;
            tick();
            cs = 1'b0; write = 1'b0;
            repeat (steps[i].ncyc - 1) tick();
            read_chk("tbl_data", 5'd0, 32'(steps[i].e_data));
            read_chk("tbl_rise", 5'd1, 32'(steps[i].e_rise));
            read_chk("tbl_fall", 5'd2, 32'(steps[i].e_fall));
            read_chk("tbl_mask", 5'd3, 32'(steps[i].e_mask));
            check("tbl_irq", {31'b0, irq}, {31'b0, steps[i].e_irq});
        end
        read_chk("unmapped5", 5'd5, 32'h0);
        read_chk("unmapped7", 5'd7, 32'h0);
        read_chk("unmapped31", 5'd31, 32'h0);

        // Glitch restarts the debounce; no intermediate load, one rise event.
        do_reset();
        din = 8'h01; repeat (3) tick();
        din = 8'h00; repeat (2) tick();
        read_chk("glitch_mid", 5'd0, 32'h00);
        din = 8'h01; repeat (7) tick();
        read_chk("glitch_edge12", 5'd0, 32'h00);
        tick();
        read_chk("glitch_edge13", 5'd0, 32'h01);
        read_chk("glitch_rise", 5'd1, 32'h01);
        bus_write(5'd1, 32'h01);
        repeat (10) tick();
        read_chk("glitch_rise_once", 5'd1, 32'h00);

        // Clear write lands on the same edge as a new rising bit: set wins.
        do_reset();
        din = 8'h05; repeat (8) tick();
        read_chk("sw_rise_pre", 5'd1, 32'h05);
        din = 8'h0D; repeat (7) tick();
        bus_write(5'd1, 32'hFF);
        read_chk("sw_rise", 5'd1, 32'h08);
        read_chk("sw_data", 5'd0, 32'h0D);

        // Reset in the middle of a debounce, then a clean restart.
        do_reset();
        bus_write(5'd3, 32'hFF);
        din = 8'h05; repeat (8) tick();
        check("mr_irq_pre", {31'b0, irq}, 32'h1);
        din = 8'h00; repeat (5) tick();
        #2 reset_n = 1'b0;
        model_clear();
        #1;
        check("mr_irq_now", {31'b0, irq}, 32'h0);
        for (int a = 0; a < 4; a++) read_chk("mr_rd_now", 5'(a), 32'h0);
        repeat (2) tick();
        reset_n = 1'b1;
        din = 8'h05;
        repeat (7) tick();
        read_chk("mr_edge7", 5'd0, 32'h00);
        tick();
        read_chk("mr_edge8", 5'd0, 32'h05);
        read_chk("mr_rise", 5'd1, 32'h05);
        read_chk("mr_fall", 5'd2, 32'h00);

        // Randomized stimulus against the model.
        do_reset();
        hold = 0;
        for (int c = 0; c < 2000; c++) begin
            if (hold == 0) begin
                if ($urandom_range(0, 1) == 0) din = din ^ (8'h01 << $urandom_range(0, 7));
                else din = 8'($urandom_range(0, 255));
                hold = $urandom_range(1, 12);
            end
            hold--;
            if ($urandom_range(0, 3) == 0) begin
                cs = ($urandom_range(0, 4) != 0);
                write = 1'b1;
                addr = 5'($urandom_range(0, 7));
                wr_data = $urandom();
            end else begin
                cs = $urandom_range(0, 1) == 1;
                write = 1'b0;
                read = cs;
                addr = 5'($urandom_range(0, 7));
            end
            tick();
            cs = 1'b0; write = 1'b0; read = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
